// File: rtl/tc_evt_pkg.sv
// Shared constants and types for the terminal-count event collector.
// The counter's period and terminal value live here so the checker and the bench agree.
package tc_evt_pkg;

    localparam int unsigned TC_PERIOD   = 8;
    localparam int unsigned CNT_W       = 3;
    localparam logic [CNT_W-1:0] TC_VALUE = 3'b111;
    localparam int unsigned DEF_EPOCH_W = 8;
    localparam int unsigned GAP_W       = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } spc_state_e;

endpackage

// File: rtl/tc_evt_fifo.sv
// Generic synchronous FIFO. pop_dat shows the head combinationally; a push when full is taken only alongside a pop.
// Backpressure: the caller sees full and decides whether to drop.
module tc_evt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // The extra pointer bit separates full from empty when the addresses coincide.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/tc_event_collector.sv
// Counts counter wraps into an epoch and queues one record per wrap; head valid 1 cycle after the wrap is seen.
// Stalled consumer: records queue up to DEPTH, later wraps are dropped and flagged. Spacing check: TC_EVT_SPACING_CHECK_EN.
module tc_event_collector
    import tc_evt_pkg::*;
#(
    parameter int EPOCH_W = DEF_EPOCH_W,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   count_out,
    input  logic               tc,
    input  logic               ld_enb,
    input  logic               clr,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [EPOCH_W-1:0] evt_data,
    output logic               overflow,
    output logic               tc_mismatch,
    output logic               spacing_err
);

    logic               tc_q;
    logic               wrap;
    logic [EPOCH_W-1:0] epoch;
    logic [EPOCH_W-1:0] epoch_nxt;
    logic               fifo_full;
    logic               fifo_empty;
    logic [EPOCH_W-1:0] fifo_dat;
    logic               pop;
    logic               ovf_set;
    logic               mm_set;

    assign wrap      = tc & ~tc_q;
    assign epoch_nxt = epoch + 1'b1;
    assign evt_valid = ~fifo_empty;
    assign pop       = evt_valid & evt_ready;
    assign evt_data  = evt_valid ? fifo_dat : '0;
    assign ovf_set   = wrap & fifo_full & ~pop;
    assign mm_set    = tc & (count_out != TC_VALUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_q  <= 1'b0;
            epoch <= '0;
        end else begin
            tc_q <= tc;
            if (wrap) epoch <= epoch_nxt;
        end
    end

    tc_evt_fifo #(
        .W     (EPOCH_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (wrap),
        .push_dat (epoch_nxt),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Set beats clear when both land on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow    <= 1'b0;
            tc_mismatch <= 1'b0;
        end else begin
            if (ovf_set)  overflow <= 1'b1;
            else if (clr) overflow <= 1'b0;
            if (mm_set)   tc_mismatch <= 1'b1;
            else if (clr) tc_mismatch <= 1'b0;
        end
    end

`ifdef TC_EVT_SPACING_CHECK_EN
    localparam logic [GAP_W-1:0] GAP_MAX = '1;

    spc_state_e       state;
    spc_state_e       state_n;
    logic [GAP_W-1:0] gap;
    logic [GAP_W-1:0] gap_n;
    logic             spc_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gap         <= '0;
            spacing_err <= 1'b0;
        end else begin
            state <= state_n;
            gap   <= gap_n;
            if (spc_set)  spacing_err <= 1'b1;
            else if (clr) spacing_err <= 1'b0;
        end
    end

    // A load restarts the phase, so a wrap coinciding with it is not a spacing sample.
    always_comb begin
        state_n = state;
        gap_n   = gap;
        spc_set = 1'b0;
        if (ld_enb) begin
            state_n = IDLE;
            gap_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wrap) begin
                        state_n = RUN;
                        gap_n   = GAP_W'(1);
                    end
                end
                RUN: begin
                    if (wrap) begin
                        spc_set = (gap != GAP_W'(TC_PERIOD));
                        gap_n   = GAP_W'(1);
                    end else begin
                        gap_n = gap + 1'b1;
                        if (gap_n == GAP_MAX) begin
                            spc_set = 1'b1;
                            state_n = IDLE;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    gap_n   = '0;
                end
            endcase
        end
    end
`else
    logic unused_ld_enb;
    assign unused_ld_enb = ld_enb;
    assign spacing_err   = 1'b0;
`endif

endmodule

// File: tb/tb_tc_event_collector.sv
// Directed bench for tc_event_collector: latency, backpressure/overflow, load hold, sticky flags, async reset.
module tb_tc_event_collector;

`ifdef TC_EVT_SPACING_CHECK_EN
    localparam logic SPC_EN = 1'b1;
`else
    localparam logic SPC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] count_out;
    logic       tc;
    logic       ld_enb;
    logic       clr;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_data;
    logic       overflow;
    logic       tc_mismatch;
    logic       spacing_err;

    int         checks = 0;
    int         passes = 0;
    logic [2:0] cnt;

    tc_event_collector #(.EPOCH_W(8), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .count_out   (count_out),
        .tc          (tc),
        .ld_enb      (ld_enb),
        .clr         (clr),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_data    (evt_data),
        .overflow    (overflow),
        .tc_mismatch (tc_mismatch),
        .spacing_err (spacing_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Inputs change 1 time unit after a rising edge; the caller resumes at the following falling edge.
    task automatic drive(input logic [2:0] c, input logic t, input logic l, input logic cl);
        @(posedge clk);
        #1;
        count_out = c;
        tc        = t;
        ld_enb    = l;
        clr       = cl;
        @(negedge clk);
    endtask

    task automatic tick();
        cnt = cnt + 3'd1;
        drive(cnt, (cnt == 3'd7), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        count_out = '0;
        tc        = 1'b0;
        ld_enb    = 1'b0;
        clr       = 1'b0;
        evt_ready = 1'b0;
        cnt       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (evt_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", evt_valid); else passes++;
        checks++; if (evt_data !== 8'd0) $display("FAIL rst_data: got %0d want 0", evt_data); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow); else passes++;
        checks++; if (tc_mismatch !== 1'b0) $display("FAIL rst_mismatch: got %b want 0", tc_mismatch); else passes++;
        checks++; if (spacing_err !== 1'b0) $display("FAIL rst_spacing: got %b want 0", spacing_err); else passes++;
    endtask

    task automatic test_free_run();
        do_reset();
        evt_ready = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            while (cnt != 3'd7) tick();
            checks++; if (evt_valid !== 1'b0) $display("FAIL fr_pre_valid[%0d]: got %b want 0", w, evt_valid); else passes++;
            tick();
            checks++; if (evt_valid !== 1'b1) $display("FAIL fr_valid[%0d]: got %b want 1", w, evt_valid); else passes++;
            checks++; if (evt_data !== 8'(w)) $display("FAIL fr_data[%0d]: got %0d want %0d", w, evt_data, w); else passes++;
            tick();
            checks++; if (evt_valid !== 1'b0) $display("FAIL fr_popped[%0d]: got %b want 0", w, evt_valid); else passes++;
        end
        checks++; if (overflow !== 1'b0) $display("FAIL fr_overflow: got %b want 0", overflow); else passes++;
        checks++; if (tc_mismatch !== 1'b0) $display("FAIL fr_mismatch: got %b want 0", tc_mismatch); else passes++;
        checks++; if (spacing_err !== 1'b0) $display("FAIL fr_spacing: got %b want 0", spacing_err); else passes++;
    endtask

    task automatic test_overflow();
        do_reset();
        evt_ready = 1'b0;
        for (int w = 1; w <= 6; w++) begin
            while (cnt != 3'd7) tick();
            tick();
            if (w == 4) begin
                checks++; if (overflow !== 1'b0) $display("FAIL ovf_at_full: got %b want 0", overflow); else passes++;
            end
        end
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else passes++;
        checks++; if (evt_data !== 8'd1) $display("FAIL ovf_stall_data: got %0d want 1", evt_data); else passes++;
        evt_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (evt_valid !== 1'b1) $display("FAIL ovf_drain_valid[%0d]: got %b want 1", k, evt_valid); else passes++;
            checks++; if (evt_data !== 8'(k)) $display("FAIL ovf_drain_data[%0d]: got %0d want %0d", k, evt_data, k); else passes++;
            tick();
        end
        checks++; if (evt_valid !== 1'b0) $display("FAIL ovf_drained: got %b want 0", evt_valid); else passes++;
        while (cnt != 3'd7) tick();
        tick();
        checks++; if (evt_data !== 8'd7) $display("FAIL ovf_next_epoch: got %0d want 7", evt_data); else passes++;
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else passes++;
    endtask

    task automatic test_load_hold();
        int         nev;
        logic [7:0] first;
        nev   = 0;
        first = '0;
        do_reset();
        evt_ready = 1'b1;
        repeat (5) begin
            drive(3'd7, 1'b1, 1'b1, 1'b0);
            if (evt_valid === 1'b1) begin nev++; first = evt_data; end
        end
        cnt = 3'd7;
        repeat (8) begin
            tick();
            if (evt_valid === 1'b1) nev++;
        end
        checks++; if (nev != 1) $display("FAIL ld_event_count: got %0d want 1", nev); else passes++;
        checks++; if (first !== 8'd1) $display("FAIL ld_first_data: got %0d want 1", first); else passes++;
        checks++; if (spacing_err !== 1'b0) $display("FAIL ld_spacing: got %b want 0", spacing_err); else passes++;
        checks++; if (tc_mismatch !== 1'b0) $display("FAIL ld_mismatch: got %b want 0", tc_mismatch); else passes++;
    endtask

    task automatic test_mismatch_clr();
        do_reset();
        evt_ready = 1'b1;
        drive(3'd2, 1'b1, 1'b0, 1'b0);
        checks++; if (tc_mismatch !== 1'b0) $display("FAIL mm_before: got %b want 0", tc_mismatch); else passes++;
        drive(3'd3, 1'b0, 1'b0, 1'b0);
        checks++; if (tc_mismatch !== 1'b1) $display("FAIL mm_set: got %b want 1", tc_mismatch); else passes++;
        drive(3'd4, 1'b0, 1'b0, 1'b1);
        checks++; if (tc_mismatch !== 1'b1) $display("FAIL mm_clr_pending: got %b want 1", tc_mismatch); else passes++;
        drive(3'd5, 1'b0, 1'b0, 1'b0);
        checks++; if (tc_mismatch !== 1'b0) $display("FAIL mm_cleared: got %b want 0", tc_mismatch); else passes++;
        drive(3'd2, 1'b1, 1'b0, 1'b1);
        drive(3'd3, 1'b0, 1'b0, 1'b0);
        checks++; if (tc_mismatch !== 1'b1) $display("FAIL mm_set_wins: got %b want 1", tc_mismatch); else passes++;
    endtask

    task automatic test_spacing();
        do_reset();
        evt_ready = 1'b1;
        drive(3'd7, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) drive(3'(i), 1'b0, 1'b0, 1'b0);
        checks++; if (spacing_err !== 1'b0) $display("FAIL spc_first: got %b want 0", spacing_err); else passes++;
        drive(3'd7, 1'b1, 1'b0, 1'b0);
        drive(3'd1, 1'b0, 1'b0, 1'b0);
        checks++; if (spacing_err !== SPC_EN) $display("FAIL spc_short: got %b want %b", spacing_err, SPC_EN); else passes++;
        checks++; if (evt_data !== 8'd2) $display("FAIL spc_data: got %0d want 2", evt_data); else passes++;
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        evt_ready = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            while (cnt != 3'd7) tick();
            tick();
        end
        evt_ready = 1'b1;
        tick();
        checks++; if (evt_data !== 8'd2) $display("FAIL rmd_head: got %0d want 2", evt_data); else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (evt_valid !== 1'b0) $display("FAIL rmd_valid: got %b want 0", evt_valid); else passes++;
        checks++; if (evt_data !== 8'd0) $display("FAIL rmd_data: got %0d want 0", evt_data); else passes++;
        cnt       = '0;
        count_out = '0;
        tc        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        while (cnt != 3'd7) tick();
        tick();
        checks++; if (evt_valid !== 1'b1) $display("FAIL rmd_post_valid: got %b want 1", evt_valid); else passes++;
        checks++; if (evt_data !== 8'd1) $display("FAIL rmd_post_data: got %0d want 1", evt_data); else passes++;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_overflow();
        test_load_hold();
        test_mismatch_clr();
        test_spacing();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tc_event_collector.md
Name: tc_event_collector

Overview:
- Downstream consumer of the 3-bit load-able counter; samples the counter's count_out, tc and ld_enb.
- Detects each terminal-count wrap and counts wraps in a wider epoch counter.
- Queues one epoch record per wrap in a small FIFO drained by a valid/ready interface.
- Flags protocol anomalies with sticky bits: tc inconsistent with count_out, wrap spacing not equal to 8 cycles, FIFO overflow.

Parameters:
- EPOCH_W, 8, width of the epoch counter and of evt_data.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- rst_n  input  1  asynchronous active-low reset.
- count_out  input  3  counter output.
- tc  input  1  counter terminal-count flag.
- ld_enb  input  1  counter load enable; marks a spacing resync.
- clr  input  1  synchronous clear of the sticky flags only.
- evt_valid  output  1  FIFO head valid.
- evt_ready  input  1  consumer accepts the head.
- evt_data  output  EPOCH_W  epoch value of the head record.
- overflow  output  1  sticky: a wrap was dropped because the FIFO was full.
- tc_mismatch  output  1  sticky: tc==1 while count_out!=3'b111.
- spacing_err  output  1  sticky: wrap spacing differs from TC_PERIOD.

Behaviour:
- Reset: asynchronous, active-low, effective immediately mid-operation.
  - All outputs 0; epoch=0; FIFO empty; tc_q=0; checker state IDLE; gap=0.
- Wrap event: `wrap = tc & ~tc_q`, registered rising edge of tc. tc held high (e.g. a load of 7 held) yields one event.
- On wrap:
  - epoch <= epoch+1, wrapping modulo 2^EPOCH_W (all-ones -> 0).
  - Push the new epoch value. The first wrap after reset pushes 1.
- Latency: wrap sampled at edge N -> evt_valid=1 and evt_data visible after edge N+1 when the FIFO was empty (1 cycle).
- Handshake:
  - Pop when evt_valid & evt_ready.
  - evt_data holds stable while evt_valid=1 and evt_ready=0.
  - evt_valid never drops without a pop.
- FIFO boundaries:
  - Push while full and no pop: record dropped, overflow<=1, epoch still increments.
  - Push and pop in the same cycle while full: both accepted, occupancy unchanged, no overflow.
  - Push and pop in the same cycle while empty is impossible, because pop requires evt_valid.
- tc_mismatch: set at any edge where tc==1 and count_out!=3'b111.
- Spacing checker FSM, states IDLE and RUN; gap is a 4-bit saturating counter.
  - IDLE: on wrap -> RUN, gap<=1.
  - RUN: gap increments each cycle.
    - On wrap: if gap!=TC_PERIOD, spacing_err<=1. Then gap<=1 and stay in RUN.
    - If gap reaches 15 without a wrap: spacing_err<=1, go to IDLE.
  - ld_enb==1 in any state: go to IDLE, gap<=0. Same-cycle wrap is ignored for spacing but still pushed.
- clr:
  - Clears overflow, tc_mismatch and spacing_err at the next edge.
  - If a set condition occurs in the same cycle, the set wins.
  - Does not touch the FIFO, epoch or FSM.

Optional Feature:
- Macro TC_EVT_SPACING_CHECK_EN.
- Defined: the spacing FSM and gap counter are compiled in; spacing_err behaves as above.
- Undefined: FSM and gap counter are omitted; spacing_err is tied to 0. The port remains.

Decomposition:
- Package tc_evt_pkg:
  - TC_PERIOD=8, CNT_W=3, TC_VALUE=3'b111.
  - Default EPOCH_W.
  - Enum typedef spc_state_e {IDLE, RUN}.
- Sub-module tc_evt_fifo:
  - Parameterized width/depth synchronous FIFO with push, pop, full, empty.
  - Pointers are one bit wider than the address.
  - Push-when-full-with-pop is allowed.

Test Plan:
- Free-running counter, 3 wraps, evt_ready=1 -> evt_data 1,2,3, each valid 1 cycle after its wrap; all flags 0.
- evt_ready=0 for 6 wraps with DEPTH=4 -> entries 1..4 retained, overflow=1; then drain with ready=1 -> 1,2,3,4; the next wrap pushes 7.
- Counter loaded with 3'b111 and ld_enb held 5 cycles -> exactly one event; spacing_err stays 0.
- Force tc=1 with count_out=3'b010 -> tc_mismatch=1 next cycle; assert clr -> cleared; with clr and the condition together -> stays 1.
- Wraps 6 cycles apart with no load (macro defined) -> spacing_err=1. Same stimulus with macro undefined -> spacing_err=0.
- Assert rst_n low mid-drain with 3 entries queued -> evt_valid=0 immediately; the next wrap after release produces evt_data=1.
